// File: rtl/vlc_rx_frame_ctrl_if.sv
// Bit-stream in / byte-and-status out bundle for the VLC receive frame controller.
// The master modport is the bit recovery side; the slave modport is the frame controller.
interface vlc_rx_frame_ctrl_if;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic [7:0] len_out;
  logic       frame_start;
  logic       frame_done;
  logic       frame_err;
  logic       busy;

  modport master (
    output bit_in, bit_valid,
    input  byte_out, byte_valid, len_out, frame_start, frame_done, frame_err, busy
  );

  modport slave (
    input  bit_in, bit_valid,
    output byte_out, byte_valid, len_out, frame_start, frame_done, frame_err, busy
  );
endinterface

// File: rtl/vlc_rx_frame_ctrl.sv
// VLC receive frame controller: hunts for the sync word in the serial bit stream,
// then walks length header -> payload -> checksum, emitting payload bytes and
// one-cycle frame status pulses. All outputs are registered (1-cycle latency).
module vlc_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_WORD    = 8'hD5,
  parameter int         MAX_LEN      = 32,
  parameter int         IDLE_TIMEOUT = 1023
) (
  input logic                clk,
  input logic                rst,
  vlc_rx_frame_ctrl_if.slave bus
);

  localparam int             TW       = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(IDLE_TIMEOUT - 1);
  localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [1:0] {S_HUNT, S_LEN, S_PAYLOAD, S_CHK} state_e;

  state_e        state_q, state_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    bytecnt_q, bytecnt_d;
  logic [7:0]    chk_q, chk_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_out_q, byte_out_d;
  logic [7:0]    len_out_q, len_out_d;
  logic          byte_valid_q, byte_valid_d;
  logic          frame_start_q, frame_start_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;
  logic          busy_q, busy_d;

  logic [7:0]    sr_nxt;
  logic          bit_last;
  logic          tmo_hit;

  // Next-state, datapath and pulse generation for the frame sequencer
  always_comb begin
    state_d       = state_q;
    bitcnt_d      = bitcnt_q;
    bytecnt_d     = bytecnt_q;
    chk_d         = chk_q;
    byte_out_d    = byte_out_q;
    len_out_d     = len_out_q;
    byte_valid_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;

    // Shift register runs in every state; decisions look at the post-shift value
    sr_nxt   = bus.bit_valid ? {sr_q[6:0], bus.bit_in} : sr_q;
    sr_d     = sr_nxt;
    bit_last = (bitcnt_q == 3'd7);

    // Idle counter only runs inside a frame; a bit always clears it
    if (state_q == S_HUNT)    tmo_d = '0;
    else if (bus.bit_valid)   tmo_d = '0;
    else                      tmo_d = tmo_q + 1'b1;

    // A bit arriving in the same cycle as the limit is processed instead
    tmo_hit = (state_q != S_HUNT) && !bus.bit_valid && (tmo_q == TMO_LAST);

    if (tmo_hit) begin
      frame_err_d = 1'b1;
      state_d     = S_HUNT;
      sr_d        = 8'h00;
      tmo_d       = '0;
    end else if (bus.bit_valid) begin
      case (state_q)
        S_HUNT: begin
          if (sr_nxt == SYNC_WORD) begin
            state_d       = S_LEN;
            frame_start_d = 1'b1;
            bitcnt_d      = 3'd0;
            tmo_d         = '0;
          end
        end
        S_LEN: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bit_last) begin
            len_out_d = sr_nxt;
            if (sr_nxt == 8'h00 || sr_nxt > MAX_LEN_B) begin
              frame_err_d = 1'b1;
              state_d     = S_HUNT;
              sr_d        = 8'h00;
            end else begin
              chk_d     = sr_nxt;
              bytecnt_d = 8'h00;
              state_d   = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bit_last) begin
            byte_out_d   = sr_nxt;
            byte_valid_d = 1'b1;
            chk_d        = chk_q ^ sr_nxt;
            bytecnt_d    = bytecnt_q + 8'd1;
            if (bytecnt_q + 8'd1 == len_out_q) state_d = S_CHK;
          end
        end
        S_CHK: begin
          bitcnt_d = bitcnt_q + 3'd1;
          if (bit_last) begin
            // Clearing sr keeps trailing checksum bits from faking a new sync
            if (sr_nxt == chk_q) frame_done_d = 1'b1;
            else                 frame_err_d  = 1'b1;
            state_d = S_HUNT;
            sr_d    = 8'h00;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end

    // busy stays high through the cycle that reports the frame outcome
    busy_d = (state_d != S_HUNT) || frame_done_d || frame_err_d;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_HUNT;
      sr_q          <= 8'h00;
      bitcnt_q      <= 3'd0;
      bytecnt_q     <= 8'h00;
      chk_q         <= 8'h00;
      tmo_q         <= '0;
      byte_out_q    <= 8'h00;
      len_out_q     <= 8'h00;
      byte_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sr_q          <= sr_d;
      bitcnt_q      <= bitcnt_d;
      bytecnt_q     <= bytecnt_d;
      chk_q         <= chk_d;
      tmo_q         <= tmo_d;
      byte_out_q    <= byte_out_d;
      len_out_q     <= len_out_d;
      byte_valid_q  <= byte_valid_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.byte_out    = byte_out_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.len_out     = len_out_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.busy        = busy_q;

endmodule
